uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver, successor of the fixed 8N1 single-register receiver.
//  - Configurable data width, parity and stop bits; 3-sample majority vote per bit.
//  - False-start rejection; per-frame parity/framing flags.
//  - Small FIFO with valid/ready output so the CPU-side bus can drain bytes late without loss.

---
 rtl/uart_rx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with 3-sample majority vote, false-start rejection,
// per-frame parity/framing flags and a small valid/ready FIFO on the output side.
module uart_rx_fifo #(
  parameter int CLK_DIV    = 5860,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  input  logic                 clear_err
);

  localparam int HALF = CLK_DIV / 2;
  localparam int TW   = $clog2(CLK_DIV);
  localparam int IW   = $clog2(DATA_BITS);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int EW   = DATA_BITS + 2;

  localparam logic [TW-1:0] T_S0   = TW'(HALF - 1);
  localparam logic [TW-1:0] T_S1   = TW'(HALF);
  localparam logic [TW-1:0] T_DEC  = TW'(HALF + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL_N = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------- input synchronizer and start-edge detect ----------------
  logic       rx_meta, rxs, rxp;
  logic [1:0] warm;
  logic       armed;
  logic       start_edge;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxp     <= 1'b1;
      warm    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
      rxp     <= rxs;
      warm    <= {warm[0], 1'b1};
      // Only a genuinely observed high line arms edge detection, so a line
      // held low across reset never looks like a start bit.
      armed   <= armed | (warm[1] & rxs);
    end
  end

  assign start_edge = armed & rxp & ~rxs;

  // ---------------- bit timer, sampling and frame FSM ----------------
  state_t                 state;
  logic [TW-1:0]          tmr;
  logic [IW-1:0]          idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   data_r;
  logic                   perr_r, ferr_r;
  logic                   s_a, s_b;
  logic                   decide, bit_val, push;
  logic [EW-1:0]          push_word;

  assign decide    = (state != IDLE) && (tmr == T_DEC);
  assign bit_val   = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
  assign push      = (state == STOP) && decide && (stop_idx == S_LAST);
  assign push_word = {ferr_r | ~bit_val, perr_r, data_r};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tmr      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      data_r   <= '0;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
      s_a      <= 1'b1;
      s_b      <= 1'b1;
    end else begin
      if (state == IDLE)        tmr <= '0;
      else if (tmr == T_LAST)   tmr <= '0;
      else                      tmr <= tmr + TW'(1);

      if (tmr == T_S0) s_a <= rxs;
      if (tmr == T_S1) s_b <= rxs;

      case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= START;
            idx      <= '0;
            stop_idx <= 1'b0;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
          end
        end
        START: begin
          if (decide) state <= bit_val ? IDLE : DATA;
        end
        DATA: begin
          if (decide) begin
            data_r[idx] <= bit_val;
            if (idx == I_LAST) begin
              idx   <= '0;
              state <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        PARITY: begin
          if (decide) begin
            perr_r <= (^data_r) ^ bit_val ^ 1'(PARITY_ODD);
            state  <= STOP;
          end
        end
        STOP: begin
          if (decide) begin
            if (!bit_val) ferr_r <= 1'b1;
            // Returning to IDLE at mid-stop lets the next start edge be caught early.
            if (stop_idx == S_LAST) state <= IDLE;
            else                    stop_idx <= stop_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- output FIFO ----------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, do_push;
  logic [EW-1:0] head;

  assign full    = (count == FULL_N);
  assign pop     = rx_valid & rx_ready;
  assign do_push = push & (~full | pop);
  assign head    = mem[rd_ptr];

  assign rx_valid = (count != '0);
  assign rx_data  = rx_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_perr  = rx_valid & head[DATA_BITS];
  assign rx_ferr  = rx_valid & head[DATA_BITS+1];

  // NOTE: storage is deliberately not reset; occupancy is tracked by count and
  // the outputs are gated by rx_valid, so stale contents are never exposed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      // A new overrun wins over a simultaneous clear.
      if (push && full && !pop) overrun <= 1'b1;
      else if (clear_err)       overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance, both at
// CLK_DIV=16 with a 4-entry FIFO, driven by vector table plus corner sequences.
module tb_uart_rx_fifo;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line0 = 1'b1, line1 = 1'b1;
  logic       ready0 = 1'b1, ready1 = 1'b1;
  logic       clr0 = 1'b0, clr1 = 1'b0;
  logic [7:0] data0, data1;
  logic       perr0, perr1, ferr0, ferr1, valid0, valid1, ovr0, ovr1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int start_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .uart_rx(line0), .rx_data(data0), .rx_perr(perr0),
    .rx_ferr(ferr0), .rx_valid(valid0), .rx_ready(ready0), .overrun(ovr0),
    .clear_err(clr0));

  uart_rx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dutp (
    .clk(clk), .rst(rst), .uart_rx(line1), .rx_data(data1), .rx_perr(perr1),
    .rx_ferr(ferr1), .rx_valid(valid1), .rx_ready(ready1), .overrun(ovr1),
    .clear_err(clr1));

  // Every accepted head entry is logged as {ferr, perr, data} with its cycle.
  logic [9:0] got0[$], got1[$];
  int         stamp0[$];

  always @(negedge clk) begin
    if (valid0 && ready0) begin
      got0.push_back({ferr0, perr0, data0});
      stamp0.push_back(cyc);
    end
    if (valid1 && ready1) got1.push_back({ferr1, perr1, data1});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) line1 = v;
    else     line0 = v;
  endtask

  // glitch_bit >= 0 places a 1-clock low pulse on the middle sample of that data bit.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input bit pbit, input bit stopv, input int glitch_bit);
    drive(sel, 1'b0);
    start_cyc = cyc;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      if (i == glitch_bit) begin
        tick(10); drive(sel, 1'b0); tick(1); drive(sel, d[i]); tick(DIV - 11);
      end else begin
        tick(DIV);
      end
    end
    if (has_par) begin drive(sel, pbit); tick(DIV); end
    drive(sel, stopv);
    tick(DIV);
    drive(sel, 1'b1);
    tick(DIV);
  endtask

  typedef struct {
    bit         sel;
    logic [7:0] d;
    bit         pbit;
    bit         stopv;
    logic [7:0] e_data;
    bit         e_perr;
    bit         e_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};

    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset rx_valid", valid0, 0);
    check("reset rx_data", data0, 0);
    check("reset rx_perr", perr0, 0);
    check("reset rx_ferr", ferr0, 0);
    check("reset overrun", ovr0, 0);
    tick(5);

    for (int v = 0; v < 7; v++) begin
      got0.delete(); got1.delete(); stamp0.delete();
      send_frame(vecs[v].sel, vecs[v].d, vecs[v].sel, vecs[v].pbit, vecs[v].stopv, -1);
      if (vecs[v].sel) begin
        check($sformatf("vec%0d count", v), got1.size(), 1);
        if (got1.size() > 0) begin
          check($sformatf("vec%0d data", v), got1[0][7:0], vecs[v].e_data);
          check($sformatf("vec%0d perr", v), got1[0][8], vecs[v].e_perr);
          check($sformatf("vec%0d ferr", v), got1[0][9], vecs[v].e_ferr);
        end
        check($sformatf("vec%0d valid after", v), valid1, 0);
      end else begin
        check($sformatf("vec%0d count", v), got0.size(), 1);
        if (got0.size() > 0) begin
          check($sformatf("vec%0d data", v), got0[0][7:0], vecs[v].e_data);
          check($sformatf("vec%0d perr", v), got0[0][8], vecs[v].e_perr);
          check($sformatf("vec%0d ferr", v), got0[0][9], vecs[v].e_ferr);
          check($sformatf("vec%0d latency ok", v), (stamp0[0] - start_cyc) <= 10 * DIV, 1);
        end
        check($sformatf("vec%0d valid after", v), valid0, 0);
      end
    end

    // Short start glitch must be rejected without storing anything.
    got0.delete();
    line0 = 1'b0; tick(5); line0 = 1'b1;
    tick(3 * DIV);
    check("glitch start no push", got0.size(), 0);
    check("glitch start valid", valid0, 0);

    // A 1-clock dip on a data bit is outvoted by the other two samples.
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 3);
    check("glitch data count", got0.size(), 1);
    if (got0.size() > 0) check("glitch data value", got0[0], 10'h0FF);

    // Fill the FIFO with the consumer stalled, then overflow by one frame.
    got0.delete();
    ready0 = 1'b0;
    for (int k = 1; k <= 4; k++) send_frame(1'b0, 8'(k), 1'b0, 1'b0, 1'b1, -1);
    check("full valid", valid0, 1);
    check("full no overrun", ovr0, 0);
    check("full head", data0, 8'h01);
    send_frame(1'b0, 8'h05, 1'b0, 1'b0, 1'b1, -1);
    check("overrun set", ovr0, 1);
    check("head held", data0, 8'h01);
    ready0 = 1'b1;
    tick(6);
    ready0 = 1'b0;
    check("drain count", got0.size(), 4);
    for (int k = 0; k < 4 && k < got0.size(); k++)
      check($sformatf("drain %0d", k), got0[k], 10'(k + 1));
    check("drained valid", valid0, 0);
    check("overrun sticky", ovr0, 1);
    clr0 = 1'b1; tick(1); clr0 = 1'b0;
    check("overrun cleared", ovr0, 0);
    ready0 = 1'b1;

    // Reset during the last data bit of 0x55 discards the partial frame.
    got0.delete();
    line0 = 1'b0; tick(DIV);
    for (int i = 0; i < 7; i++) begin
      line0 = (8'h55 >> i) & 1'b1;
      tick(DIV);
    end
    line0 = 1'b0;
    tick(4);
    rst = 1'b1; tick(2); rst = 1'b0;
    tick(DIV - 6);
    line0 = 1'b1;
    tick(3 * DIV);
    check("rst midframe no push", got0.size(), 0);
    check("rst midframe valid", valid0, 0);
    send_frame(1'b0, 8'h66, 1'b0, 1'b0, 1'b1, -1);
    check("post-rst count", got0.size(), 1);
    if (got0.size() > 0) check("post-rst frame", got0[0], 10'h066);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
